uart_rx_buffered: RTL and testbench

UART receiver with a small show-ahead receive FIFO. It recovers 8N1 frames from the `uio_in[5]` receive line of the nanoV top level and buffers them for the CPU's memory-mapped peripheral logic. It is the receive-side counterpart of the existing `uart_tx`, with the same clock and bit-rate parameters. Firmware drains it by polling `rx_valid` and pulsing `rd_en`.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/uart_rx_buffered.sv | 149 ++++++++++++++
 tb/tb_uart_rx_buffered.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and bit-timing helpers,
// used by uart_rx_buffered and intended for uart_tx as well.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } uart_rx_state_t;

   // Whole clock cycles per line bit (truncating division).
   function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                  input int unsigned bit_rate);
      return clk_hz / bit_rate;
   endfunction

   // Width of a counter that must reach n-1; never narrower than one bit.
   function automatic int unsigned counter_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a show-ahead head output
// that reads zero while the FIFO is empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic             dropped,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // A pop frees a slot on the same edge, so a full FIFO still accepts the push.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dropped = push && full && !pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // NOTE: storage is deliberately left out of reset; the pointers define
   // which entries are live and the head output is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver feeding a small show-ahead FIFO, with sticky overrun
// and framing-error flags for a polled memory-mapped peripheral.
module uart_rx_buffered
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 24_000_000,
   parameter int BIT_RATE   = 115_200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rxd,
   input  logic       rd_en,
   input  logic       clr_err,
   output logic [7:0] rd_data,
   output logic       rx_valid,
   output logic       fifo_full,
   output logic       overrun,
   output logic       framing_err
);

   localparam int CPB      = cycles_per_bit(CLK_HZ, BIT_RATE);
   localparam int HALF_BIT = CPB / 2;
   localparam int CNT_W    = counter_width(CPB);

   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CPB - 1);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

   logic rx_meta;
   logic rx_sync;
   logic rx_prev;
   logic fall;

   uart_rx_state_t   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             push;
   logic             frame_bad;

   logic             fifo_empty;
   logic             fifo_dropped;

   // Synchronizer and edge-history flops reset high to match an idle line.
   // NOTE: every clocked block uses non-blocking assignments so all flops
   // sample pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= uart_rxd;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign fall = rx_prev && !rx_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   // NOTE: every output of this block is given a default first, so no path
   // through the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      bit_d     = bit_q;
      shift_d   = shift_q;
      push      = 1'b0;
      frame_bad = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (fall) state_d = ST_START;
         end
         ST_START: begin
            if (cnt_q == HALF_END) begin
               cnt_d = '0;
               bit_d = '0;
               state_d = rx_sync ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt_q == BIT_END) begin
               cnt_d   = '0;
               shift_d = {rx_sync, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            // Leaving at mid-stop-bit lets the next start edge follow immediately.
            if (cnt_q == BIT_END) begin
               cnt_d     = '0;
               state_d   = ST_IDLE;
               push      = rx_sync;
               frame_bad = !rx_sync;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (shift_q),
      .pop       (rd_en),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .dropped   (fifo_dropped),
      .head      (rd_data)
   );

   assign rx_valid = !fifo_empty;

   // Sticky flags: a set in the same cycle as clr_err takes priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun     <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         if (fifo_dropped) overrun <= 1'b1;
         else if (clr_err) overrun <= 1'b0;

         if (frame_bad)    framing_err <= 1'b1;
         else if (clr_err) framing_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: frame-level reference model with
// a per-cycle output compare, directed scenarios and randomized traffic.
module tb_uart_rx_buffered;

   localparam int CPB       = 208;
   localparam int HALF      = 104;
   localparam int DEPTH     = 4;
   localparam int FRAME     = 10 * CPB;
   // Pin edge n -> push edge: 2 sync cycles, stop sample at E+HALF+9*CPB, +1 edge.
   localparam int PUSH_EDGE = 2 + HALF + 9 * CPB + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       uart_rxd;
   logic       rd_en;
   logic       clr_err;
   logic [7:0] rd_data;
   logic       rx_valid;
   logic       fifo_full;
   logic       overrun;
   logic       framing_err;

   int n_checks = 0;
   int n_fail   = 0;

   uart_rx_buffered dut (
      .clk         (clk),
      .rst         (rst),
      .uart_rxd    (uart_rxd),
      .rd_en       (rd_en),
      .clr_err     (clr_err),
      .rd_data     (rd_data),
      .rx_valid    (rx_valid),
      .fifo_full   (fifo_full),
      .overrun     (overrun),
      .framing_err (framing_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint     edge_no;
      bit         good;
      logic [7:0] data;
   } ev_t;

   logic [7:0] mq[$];
   ev_t        evq[$];
   bit         m_ovr = 1'b0;
   bit         m_ferr = 1'b0;
   longint     cyc = 0;
   bit         checking = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: whole-frame events applied on the edge the byte lands.
   always @(posedge clk) begin : model
      bit   pop_ok, set_ovr, set_ferr;
      ev_t  ev;
      cyc++;
      if (rst) begin
         mq.delete();
         evq.delete();
         m_ovr  = 1'b0;
         m_ferr = 1'b0;
      end else begin
         set_ovr  = 1'b0;
         set_ferr = 1'b0;
         pop_ok   = rd_en && (mq.size() > 0);
         if (pop_ok) void'(mq.pop_front());
         if (evq.size() > 0 && evq[0].edge_no == cyc) begin
            ev = evq.pop_front();
            if (!ev.good)              set_ferr = 1'b1;
            else if (mq.size() < DEPTH) mq.push_back(ev.data);
            else                        set_ovr = 1'b1;
         end
         m_ovr  = set_ovr  ? 1'b1 : (clr_err ? 1'b0 : m_ovr);
         m_ferr = set_ferr ? 1'b1 : (clr_err ? 1'b0 : m_ferr);
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         check("rx_valid",    rx_valid,    mq.size() != 0);
         check("rd_data",     rd_data,     (mq.size() != 0) ? mq[0] : 8'h00);
         check("fifo_full",   fifo_full,   mq.size() == DEPTH);
         check("overrun",     overrun,     m_ovr);
         check("framing_err", framing_err, m_ferr);
      end
   end

   // All tasks start and end #1 after a rising edge.
   task automatic idle(input int n);
      uart_rxd = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] data, input bit stop_bit,
                             input bit pop_at_stop, input bit clr_at_stop);
      logic [9:0] bits;
      ev_t        ev;
      bits       = {stop_bit, data, 1'b0};
      ev.edge_no = cyc + PUSH_EDGE;
      ev.good    = stop_bit;
      ev.data    = data;
      evq.push_back(ev);
      for (int c = 0; c < FRAME; c++) begin
         uart_rxd = bits[c / CPB];
         if (c == PUSH_EDGE - 1) begin
            if (pop_at_stop) rd_en   = 1'b1;
            if (clr_at_stop) clr_err = 1'b1;
         end
         if (c == PUSH_EDGE) begin
            if (pop_at_stop) rd_en   = 1'b0;
            if (clr_at_stop) clr_err = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      if (!stop_bit) idle(CPB);
   endtask

   task automatic read_expect(input logic [7:0] exp, input string name);
      check({name, "_valid"}, rx_valid, 1);
      check(name, rd_data, exp);
      rd_en = 1'b1;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      @(posedge clk);
      #1;
      clr_err = 1'b0;
   endtask

   initial begin : watchdog
      #1_500_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bit done;
      rst      = 1'b1;
      uart_rxd = 1'b1;
      rd_en    = 1'b0;
      clr_err  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst      = 1'b0;
      checking = 1'b1;

      check("reset_rx_valid",    rx_valid,    0);
      check("reset_rd_data",     rd_data,     0);
      check("reset_fifo_full",   fifo_full,   0);
      check("reset_overrun",     overrun,     0);
      check("reset_framing_err", framing_err, 0);
      idle(20);

      // Single frame, then one pop empties it.
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      read_expect(8'hA5, "single_a5");
      check("single_empty_valid", rx_valid, 0);
      check("single_empty_data",  rd_data,  0);

      // Half-bit glitch is a false start.
      uart_rxd = 1'b0;
      repeat (HALF) begin
         @(posedge clk);
         #1;
      end
      idle(FRAME + 100);
      check("glitch_valid", rx_valid,    0);
      check("glitch_ferr",  framing_err, 0);
      check("glitch_ovr",   overrun,     0);

      // Five back-to-back frames with no reads: the fifth is dropped.
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b1, 1'b0, 1'b0);
         if (i == 4) check("fill_full_after4", fifo_full, 1);
      end
      check("fill_overrun", overrun, 1);
      for (int i = 1; i <= 4; i++) read_expect(8'(i), "fill_read");
      check("fill_drained", rx_valid, 0);
      pulse_clr();
      check("fill_ovr_cleared", overrun, 0);

      // Full FIFO, pop on the exact push edge of a fifth frame.
      for (int i = 0; i < 4; i++) send_frame(8'hC0 + 8'(i), 1'b1, 1'b0, 1'b0);
      check("pp_full_before", fifo_full, 1);
      send_frame(8'h55, 1'b1, 1'b1, 1'b0);
      check("pp_no_overrun", overrun,   0);
      check("pp_still_full", fifo_full, 1);
      read_expect(8'hC1, "pp_read");
      read_expect(8'hC2, "pp_read");
      read_expect(8'hC3, "pp_read");
      read_expect(8'h55, "pp_last");
      check("pp_drained", rx_valid, 0);

      // Framing errors and the set-beats-clear rule.
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      check("ferr_set",   framing_err, 1);
      check("ferr_empty", rx_valid,    0);
      pulse_clr();
      check("ferr_cleared", framing_err, 0);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      check("ferr_set_wins", framing_err, 1);
      pulse_clr();

      // Reset in data bit 4 of 0xFF abandons the frame.
      uart_rxd = 1'b0;
      repeat (CPB) begin
         @(posedge clk);
         #1;
      end
      idle(4 * CPB + 100);
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      idle(6 * CPB);
      check("rst_nothing", rx_valid, 0);
      send_frame(8'h12, 1'b1, 1'b0, 1'b0);
      read_expect(8'h12, "rst_read");
      check("rst_only_one", rx_valid,    0);
      check("rst_no_ferr",  framing_err, 0);
      check("rst_no_ovr",   overrun,     0);

      // Randomized traffic with concurrent random reads and clears.
      done = 1'b0;
      fork
         begin
            for (int f = 0; f < 8; f++) begin
               idle($urandom_range(0, 200));
               send_frame(8'($urandom), $urandom_range(0, 4) != 0, 1'b0, 1'b0);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               rd_en   = $urandom_range(0, 99) < 3;
               clr_err = $urandom_range(0, 199) == 0;
            end
            rd_en   = 1'b0;
            clr_err = 1'b0;
         end
      join
      rd_en = 1'b1;
      repeat (DEPTH + 2) begin
         @(posedge clk);
         #1;
      end
      rd_en = 1'b0;
      check("final_drained", rx_valid, 0);
      idle(10);

      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
